// File: rtl/seg_scan_if.sv
// Bus between a display controller and seg_scan_driver: digit-buffer writes,
// scan enable and the registered multiplexed segment/anode drive.
interface seg_scan_if;
    logic       load_syn;
    logic [1:0] wr_addr;
    logic [6:0] seg_in;
    logic       scan_en;
    logic [6:0] seg_out;
    logic [3:0] an;
    logic [1:0] digit_idx;

    modport master (
        output load_syn, wr_addr, seg_in, scan_en,
        input  seg_out, an, digit_idx
    );

    modport slave (
        input  load_syn, wr_addr, seg_in, scan_en,
        output seg_out, an, digit_idx
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with a write-anytime digit buffer.
// Define SEG_SCAN_BLANK_EN to insert an all-off gap of BLANK_CYC clocks between digits.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input logic       clk,
    input logic       rst_syn,
    seg_scan_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20)) begin : g_bad_scan_div
        $error("seg_scan_driver: SCAN_DIV must be within 2..2^20");
    end
    if (BLANK_CYC < 1 || BLANK_CYC > 255) begin : g_bad_blank_cyc
        $error("seg_scan_driver: BLANK_CYC must be within 1..255");
    end

    logic [6:0]    digit_buf [4];
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [6:0]    seg_q;
    logic [3:0]    an_q;
    logic          showing;

`ifdef SEG_SCAN_BLANK_EN
    typedef enum logic {SHOW, BLANK} state_t;
    localparam logic [7:0] BLANK_MAX = 8'(BLANK_CYC - 1);

    state_t     state;
    logic [7:0] blank_cnt;

    assign showing = bus.scan_en && (state == SHOW);
`else
    assign showing = bus.scan_en;
`endif

    // The output register samples the buffer and index as they stood before
    // this edge, so any write or index change reaches the pins one clock later.
    always_ff @(posedge clk) begin
        if (!rst_syn) begin
            for (int i = 0; i < 4; i++) begin
                digit_buf[i] <= '0;
            end
            cnt   <= '0;
            idx   <= '0;
            seg_q <= '0;
            an_q  <= 4'b1111;
`ifdef SEG_SCAN_BLANK_EN
            state     <= SHOW;
            blank_cnt <= '0;
`endif
        end else begin
            if (bus.load_syn) begin
                digit_buf[bus.wr_addr] <= bus.seg_in;
            end

            if (bus.scan_en) begin
`ifdef SEG_SCAN_BLANK_EN
                case (state)
                    SHOW: begin
                        if (cnt == CNT_MAX) begin
                            cnt   <= '0;
                            state <= BLANK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    BLANK: begin
                        if (blank_cnt == BLANK_MAX) begin
                            blank_cnt <= '0;
                            idx       <= idx + 2'd1;
                            state     <= SHOW;
                        end else begin
                            blank_cnt <= blank_cnt + 8'd1;
                        end
                    end
                    default: state <= SHOW;
                endcase
`else
                if (cnt == CNT_MAX) begin
                    cnt <= '0;
                    idx <= idx + 2'd1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`endif
            end

            if (showing) begin
                seg_q <= digit_buf[idx];
                an_q  <= ~(4'b0001 << idx);
            end else begin
                seg_q <= '0;
                an_q  <= 4'b1111;
            end
        end
    end

    assign bus.seg_out   = seg_q;
    assign bus.an        = an_q;
    assign bus.digit_idx = idx;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver with SCAN_DIV=4, BLANK_CYC=2;
// the blanking sequence runs when SEG_SCAN_BLANK_EN is defined.
module tb_seg_scan_driver;
    logic clk = 1'b0;
    logic rst_syn;
    int   errors = 0;
    int   checks = 0;

    logic [6:0] pats   [4];
    logic [3:0] an_tab [4];

    seg_scan_if bus ();

    seg_scan_driver #(
        .SCAN_DIV (4),
        .BLANK_CYC(2)
    ) dut (
        .clk    (clk),
        .rst_syn(rst_syn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic load, input logic [1:0] addr,
                                 input logic [6:0] seg, input logic en);
        rst_syn      = rst;
        bus.load_syn = load;
        bus.wr_addr  = addr;
        bus.seg_in   = seg;
        bus.scan_en  = en;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_an,
                               input logic [6:0] exp_seg, input logic [1:0] exp_idx);
        checks++;
        assert (bus.an === exp_an)
        else begin
            errors++;
            $error("[TB] FAIL %s an: observed=%b expected=%b", tag, bus.an, exp_an);
        end
        checks++;
        assert (bus.seg_out === exp_seg)
        else begin
            errors++;
            $error("[TB] FAIL %s seg_out: observed=%h expected=%h", tag, bus.seg_out, exp_seg);
        end
        checks++;
        assert (bus.digit_idx === exp_idx)
        else begin
            errors++;
            $error("[TB] FAIL %s digit_idx: observed=%0d expected=%0d", tag, bus.digit_idx, exp_idx);
        end
        checks++;
        assert ($countones(~bus.an) <= 1)
        else begin
            errors++;
            $error("[TB] FAIL %s an_onehot: observed=%b expected=at most one low bit", tag, bus.an);
        end
    endtask

    initial begin
        pats[0] = 7'h06; pats[1] = 7'h5B; pats[2] = 7'h4F; pats[3] = 7'h66;
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101; an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;

        // Reset held two clocks while a write is attempted: everything must stay cleared.
        applyStimulus(1'b0, 1'b1, 2'd0, 7'h7F, 1'b1);
        step();
        step();
        checkOutput("reset", 4'b1111, 7'h00, 2'd0);

        applyStimulus(1'b1, 1'b0, 2'd0, 7'h00, 1'b1);
        step();
        checkOutput("first_after_reset", 4'b1110, 7'h00, 2'd0);

        // Clean restart, then fill the buffer with the scan frozen.
        applyStimulus(1'b0, 1'b0, 2'd0, 7'h00, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 2'(i), pats[i], 1'b0);
            step();
        end
        checkOutput("load_frozen", 4'b1111, 7'h00, 2'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 7'h00, 1'b1);

`ifdef SEG_SCAN_BLANK_EN
        // Each slot: 4 clocks lit, then 2 clocks all-off.
        for (int n = 1; n <= 30; n++) begin
            step();
            if (((n - 1) % 6) < 4)
                checkOutput("blank_scan_lit", an_tab[((n - 1) / 6) % 4], pats[((n - 1) / 6) % 4],
                            2'((n / 6) % 4));
            else
                checkOutput("blank_scan_gap", 4'b1111, 7'h00, 2'((n / 6) % 4));
        end
`else
        for (int n = 1; n <= 20; n++) begin
            step();
            checkOutput("scan", an_tab[((n - 1) / 4) % 4], pats[((n - 1) / 4) % 4], 2'((n / 4) % 4));
        end

        // Slot 1 is on display; overwrite it and watch the two-edge path.
        step();
        checkOutput("live_pre", 4'b1101, 7'h5B, 2'd1);
        applyStimulus(1'b1, 1'b1, 2'd1, 7'h7F, 1'b1);
        step();
        checkOutput("live_write_edge", 4'b1101, 7'h5B, 2'd1);
        applyStimulus(1'b1, 1'b0, 2'd0, 7'h00, 1'b1);
        step();
        checkOutput("live_visible", 4'b1101, 7'h7F, 2'd1);
        step();
        checkOutput("live_tick", 4'b1101, 7'h7F, 2'd2);
        step();
        checkOutput("slot2_start", 4'b1011, 7'h4F, 2'd2);
        step();
        checkOutput("slot2_mid", 4'b1011, 7'h4F, 2'd2);

        // Pause mid-slot for 10 clocks; the remaining two slot clocks follow on resume.
        applyStimulus(1'b1, 1'b0, 2'd0, 7'h00, 1'b0);
        for (int n = 0; n < 10; n++) begin
            step();
            checkOutput("paused", 4'b1111, 7'h00, 2'd2);
        end
        applyStimulus(1'b1, 1'b0, 2'd0, 7'h00, 1'b1);
        step();
        checkOutput("resume_1", 4'b1011, 7'h4F, 2'd2);
        step();
        checkOutput("resume_tick", 4'b1011, 7'h4F, 2'd3);
        step();
        checkOutput("resume_next", 4'b0111, 7'h66, 2'd3);
        step();
        step();
        step();
        checkOutput("slot3_tick", 4'b0111, 7'h66, 2'd0);
        step();
        checkOutput("slot0_again", 4'b1110, 7'h06, 2'd0);
        step();
        step();

        // Write slot 1 on the very edge that leaves slot 0.
        applyStimulus(1'b1, 1'b1, 2'd1, 7'h3F, 1'b1);
        step();
        checkOutput("load_on_tick", 4'b1110, 7'h06, 2'd1);
        applyStimulus(1'b1, 1'b0, 2'd0, 7'h00, 1'b1);
        step();
        checkOutput("after_load_tick", 4'b1101, 7'h3F, 2'd1);
`endif

        // Reset mid-scan with a coincident write: the write is discarded.
        applyStimulus(1'b0, 1'b1, 2'd0, 7'h77, 1'b1);
        step();
        checkOutput("midscan_reset", 4'b1111, 7'h00, 2'd0);
        applyStimulus(1'b1, 1'b0, 2'd0, 7'h00, 1'b1);
        step();
        checkOutput("post_midscan_reset", 4'b1110, 7'h00, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clk cycles per digit slot (legal 2..2^20).
REQ-002 SHALL have parameter BLANK_CYC, default 16, clk cycles of all-off gap between digits (used only with SEG_SCAN_BLANK_EN; legal 1..255).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port rst_syn, input, 1: one clock; reset is synchronous and active-low.
REQ-005 SHALL have port load_syn, input, 1, write strobe for the digit buffer.
REQ-006 SHALL have port wr_addr, input, 2, digit slot written when load_syn=1.
REQ-007 SHALL have port seg_in, input, 7, segment pattern {g,f,e,d,c,b,a} from the upstream BCD-to-seven decoder, active-high.
REQ-008 SHALL have port scan_en, input, 1, 1=scan running, 0=display off and scan frozen.
REQ-009 SHALL have port seg_out, output, 7, registered segment drive, active-high.
REQ-010 SHALL have port an, output, 4, registered digit anode enables, active-low, at most one bit low.
REQ-011 SHALL have port digit_idx, output, 2, registered index of the digit currently selected.

Function
REQ-012 SHALL hold a 4x7 digit buffer; load_syn=1 at a rising edge writes seg_in to buf[wr_addr]; load_syn=0 leaves buf unchanged.
REQ-013 SHALL run prescaler cnt 0..SCAN_DIV-1 while scan_en=1, wrapping to 0; tick=1 in the cycle cnt==SCAN_DIV-1.
REQ-014 SHALL, without blanking, advance digit_idx on tick: 0->1->2->3->0.
REQ-015 SHALL register outputs every cycle: seg_out<=buf[digit_idx], an<=~(4'b0001<<digit_idx); one-cycle latency from index/buffer change to outputs.
REQ-016 SHALL make a write to the displayed slot visible on seg_out exactly 2 edges after the write edge: buffer update, then output register.
REQ-017 SHALL, on load_syn coincident with tick, perform both: write completes, index advances, next seg_out uses the post-write buffer at the new index.
REQ-018 SHALL, while scan_en=0, hold cnt and digit_idx, drive an=4'b1111 and seg_out=7'h00, and accept buffer writes; on scan_en rising, resume from held cnt/digit_idx.
REQ-019 SHALL never drive more than one an bit low in any cycle, including at scan_en transitions and with blanking.

Reset
REQ-020 SHALL, on rst_syn=0 at a rising edge, set cnt=0, digit_idx=0, buffer all 7'h00, state=SHOW, an=4'b1111, seg_out=7'h00; rst_syn overrides load_syn and scan_en.
REQ-021 SHALL, in the first edge after rst_syn returns to 1 with scan_en=1, drive an=4'b1110, seg_out=buf[0].
REQ-022 SHALL apply reset mid-scan or mid-blank identically, discarding the current slot and any same-cycle write.

Configuration
REQ-023 SHALL support macro SEG_SCAN_BLANK_EN; when undefined, behaviour is REQ-014 only, no blank state or counter synthesised.
REQ-024 SHALL, with SEG_SCAN_BLANK_EN defined, use FSM states SHOW and BLANK: SHOW --tick--> BLANK (index held, cnt held at 0); BLANK counts BLANK_CYC cycles, then advances digit_idx and enters SHOW with cnt=0.
REQ-025 SHALL, in BLANK, drive an=4'b1111 and seg_out=7'h00 (registered, one-cycle latency as REQ-015); scan_en=0 in BLANK freezes the blank counter.

Verification
REQ-026 SHALL verify reset: rst_syn=0 two cycles with load_syn=1 -> an=1111, seg_out=00, digit_idx=0, buffer stays 00.
REQ-027 SHALL verify scan order: SCAN_DIV=4, load 7'h06,5B,4F,66 to slots 0..3, scan_en=1 -> an cycles 1110,1101,1011,0111 every 4 clks with seg_out 06,5B,4F,66, wrapping.
REQ-028 SHALL verify live update: write 7'h7F to displayed slot -> seg_out=7F 2 edges later, an unchanged.
REQ-029 SHALL verify simultaneous load and tick: write slot 1 on the tick leaving slot 0 -> next output an=1101 with new pattern.
REQ-030 SHALL verify scan_en=0 for 10 clks mid-slot -> an=1111, seg_out=00, digit_idx frozen; resume completes the remaining slot cycles.
REQ-031 SHALL verify with SEG_SCAN_BLANK_EN, SCAN_DIV=4, BLANK_CYC=2 -> each 4-clk digit slot followed by 2 clks an=1111, and at most one an bit low in every cycle.
